// File: rtl/cp0_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit_if
// Purpose  : Request/response bundle between the control unit and CP0.
// Revision : 1.0 - initial release
// ============================================================================
interface cp0_unit_if;
    logic [5:0]  ext_int;
    logic        ex_wb;
    logic [4:0]  ex_code;
    logic        eret_wb;
    logic        branch_delay;
    logic [31:0] wb_pc;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        cp0_ie;
    logic        cp0_exl;
    logic [7:0]  cp0_int_mask;
    logic [7:0]  cp0_int_sig;
    logic        cp0_hlt;
    logic        cp0_eret;
    logic        cp0_flush;
    logic [31:0] cp0_npc;
    logic [31:0] cp0_epc;

    modport master (
        output ext_int, ex_wb, ex_code, eret_wb, branch_delay, wb_pc,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, cp0_ie, cp0_exl, cp0_int_mask, cp0_int_sig,
               cp0_hlt, cp0_eret, cp0_flush, cp0_npc, cp0_epc
    );

    modport slave (
        input  ext_int, ex_wb, ex_code, eret_wb, branch_delay, wb_pc,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, cp0_ie, cp0_exl, cp0_int_mask, cp0_int_sig,
               cp0_hlt, cp0_eret, cp0_flush, cp0_npc, cp0_epc
    );
endinterface
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Purpose  : Coprocessor-0 register file (Status/Cause/EPC) with RUN/HALT
//            exception sequencer for the 5-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] EXC_VEC    = 32'h0000_0080,
    parameter logic [31:0] HALT_VEC   = 32'h0000_0100,
    parameter logic [31:0] STATUS_RST = 32'h0000_C001
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cp0_unit_if.slave   bus
);

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_halt = 1'b1;

    localparam logic [4:0] c_reg_status = 5'd12;
    localparam logic [4:0] c_reg_cause  = 5'd13;
    localparam logic [4:0] c_reg_epc    = 5'd14;

    localparam logic [4:0] c_code_int    = 5'd0;
    localparam logic [4:0] c_code_hlt    = 5'd1;
    localparam logic [4:0] c_code_resume = 5'd2;

    logic [0:0]  r_state;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [7:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_exc_hlt;
    logic        w_exc_resume;
    logic        w_mtc0;
    logic [7:0]  w_ip_next;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;
    logic [31:0] w_npc;

    assign w_exc_hlt    = bus.ex_wb && (bus.ex_code == c_code_hlt);
    assign w_exc_resume = bus.ex_wb && (bus.ex_code == c_code_resume);
    // The WB instruction is squashed by any exception or ERET, so its MTC0 dies too.
    assign w_mtc0       = bus.cp0_we && !bus.ex_wb && !bus.eret_wb;

    // Sticky IP7/IP6: a new request in the same cycle outranks the clear.
    always_comb begin
        w_ip_next      = r_ip;
        w_ip_next[7]   = bus.ext_int[5] | (r_ip[7] & ~w_exc_hlt);
        w_ip_next[6]   = bus.ext_int[4] | (r_ip[6] & ~w_exc_resume);
        w_ip_next[5:2] = bus.ext_int[3:0];
        if (w_mtc0 && (bus.cp0_waddr == c_reg_cause)) begin
            w_ip_next[1:0] = bus.cp0_wdata[9:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_run;
            r_im       <= STATUS_RST[15:8];
            r_exl      <= STATUS_RST[1];
            r_ie       <= STATUS_RST[0];
            r_bd       <= 1'b0;
            r_ip       <= 8'h00;
            r_exc_code <= 5'd0;
            r_epc      <= 32'h0000_0000;
        end else begin
            r_ip <= w_ip_next;

            if (w_exc_hlt) begin
                r_state <= c_st_halt;
            end else if (w_exc_resume) begin
                r_state <= c_st_run;
            end

            if (bus.ex_wb) begin
                if (w_exc_resume) begin
                    r_exl      <= 1'b0;
                    r_exc_code <= c_code_resume;
                end else begin
                    r_exl      <= 1'b1;
                    r_exc_code <= bus.ex_code;
                    r_bd       <= bus.branch_delay;
                    // EPC points at the branch when the faulting instruction sits in its delay slot.
                    r_epc      <= bus.branch_delay ? (bus.wb_pc - 32'd4) : bus.wb_pc;
                end
            end else if (bus.eret_wb) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (bus.cp0_waddr)
                    c_reg_status: begin
                        r_im  <= bus.cp0_wdata[15:8];
                        r_exl <= bus.cp0_wdata[1];
                        r_ie  <= bus.cp0_wdata[0];
                    end
                    c_reg_epc: r_epc <= bus.cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign w_status = {16'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, 15'b0, r_ip, 1'b0, r_exc_code, 2'b0};

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (bus.cp0_raddr)
            c_reg_status: w_rdata = w_status;
            c_reg_cause:  w_rdata = w_cause;
            c_reg_epc:    w_rdata = r_epc;
            default:      w_rdata = 32'h0000_0000;
        endcase
    end

    always_comb begin
        w_npc = EXC_VEC;
        if (bus.ex_wb) begin
            if (bus.ex_code == c_code_hlt) begin
                w_npc = HALT_VEC;
            end else if (bus.ex_code == c_code_resume) begin
                w_npc = r_epc;
            end else begin
                w_npc = EXC_VEC;
            end
        end else if (bus.eret_wb) begin
            w_npc = r_epc;
        end else if (r_state == c_st_halt) begin
            w_npc = HALT_VEC;
        end
    end

    assign bus.cp0_rdata    = w_rdata;
    assign bus.cp0_ie       = r_ie;
    assign bus.cp0_exl      = r_exl;
    assign bus.cp0_int_mask = r_im;
    assign bus.cp0_int_sig  = r_ip;
    assign bus.cp0_hlt      = (r_state == c_st_halt);
    assign bus.cp0_eret     = bus.eret_wb & ~bus.ex_wb;
    assign bus.cp0_flush    = bus.ex_wb | bus.eret_wb;
    assign bus.cp0_npc      = w_npc;
    assign bus.cp0_epc      = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Purpose  : Directed self-checking bench for cp0_unit with expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

    logic clk;
    logic rst;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic pop_reg(input logic [4:0] addr);
        bus.cp0_raddr = addr;
        #1;
        pop_cmp(bus.cp0_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_wb        = 1'b0;
        bus.ex_code      = 5'd0;
        bus.eret_wb      = 1'b0;
        bus.branch_delay = 1'b0;
        bus.wb_pc        = 32'h0;
        bus.cp0_we       = 1'b0;
        bus.cp0_waddr    = 5'd0;
        bus.cp0_wdata    = 32'h0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.ext_int = 6'h00;
        bus.cp0_raddr = 5'd0;
        idle();

        // Reset
        tick();
        tick();
        rst = 1'b0;
        push("rst_status", 32'h0000_C001);
        push("rst_cause",  32'h0);
        push("rst_epc",    32'h0);
        push("rst_reg20",  32'h0);
        push("rst_hlt",    32'h0);
        push("rst_ie",     32'h1);
        push("rst_exl",    32'h0);
        push("rst_mask",   32'hC0);
        push("rst_ipsig",  32'h0);
        pop_reg(5'd12);
        pop_reg(5'd13);
        pop_reg(5'd14);
        pop_reg(5'd20);
        pop_cmp({31'b0, bus.cp0_hlt});
        pop_cmp({31'b0, bus.cp0_ie});
        pop_cmp({31'b0, bus.cp0_exl});
        pop_cmp({24'b0, bus.cp0_int_mask});
        pop_cmp({24'b0, bus.cp0_int_sig});

        // Halt entry
        bus.ext_int = 6'b100000;
        push("ip7_capture", 32'h80);
        tick();
        bus.ext_int = 6'h00;
        pop_cmp({24'b0, bus.cp0_int_sig});
        bus.ex_wb = 1'b1; bus.ex_code = 5'd1;
        bus.wb_pc = 32'h0000_3010; bus.branch_delay = 1'b1;
        push("hlt_npc",   32'h0000_0100);
        push("hlt_flush", 32'h1);
        push("hlt_eret",  32'h0);
        #1;
        pop_cmp(bus.cp0_npc);
        pop_cmp({31'b0, bus.cp0_flush});
        pop_cmp({31'b0, bus.cp0_eret});
        push("hlt_state",  32'h1);
        push("hlt_status", 32'h0000_C003);
        push("hlt_epc",    32'h0000_300C);
        push("hlt_cause",  32'h8000_0004);
        push("hlt_npc_idle", 32'h0000_0100);
        tick();
        idle();
        #1;
        pop_cmp({31'b0, bus.cp0_hlt});
        pop_reg(5'd12);
        pop_reg(5'd14);
        pop_reg(5'd13);
        pop_cmp(bus.cp0_npc);

        // Resume from HALT
        bus.ext_int = 6'b010000;
        push("ip6_capture", 32'h40);
        tick();
        bus.ext_int = 6'h00;
        pop_cmp({24'b0, bus.cp0_int_sig});
        bus.ex_wb = 1'b1; bus.ex_code = 5'd2;
        push("res_npc", 32'h0000_300C);
        #1;
        pop_cmp(bus.cp0_npc);
        push("res_state", 32'h0);
        push("res_exl",   32'h0);
        push("res_ipsig", 32'h0);
        push("res_cause", 32'h8000_0008);
        push("res_epc",   32'h0000_300C);
        tick();
        idle();
        pop_cmp({31'b0, bus.cp0_hlt});
        pop_cmp({31'b0, bus.cp0_exl});
        pop_cmp({24'b0, bus.cp0_int_sig});
        pop_reg(5'd13);
        pop_reg(5'd14);

        // ERET beats MTC0 to EPC
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd12; bus.cp0_wdata = 32'h0000_C003;
        push("mtc0_exl", 32'h1);
        tick();
        idle();
        pop_cmp({31'b0, bus.cp0_exl});
        bus.eret_wb = 1'b1;
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
        push("eret_npc",   32'h0000_300C);
        push("eret_eret",  32'h1);
        push("eret_flush", 32'h1);
        #1;
        pop_cmp(bus.cp0_npc);
        pop_cmp({31'b0, bus.cp0_eret});
        pop_cmp({31'b0, bus.cp0_flush});
        push("eret_epc", 32'h0000_300C);
        push("eret_exl", 32'h0);
        tick();
        idle();
        pop_cmp(bus.cp0_epc);
        pop_cmp({31'b0, bus.cp0_exl});

        // Plain MTC0 to EPC
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'h0000_4000;
        push("mtc0_epc", 32'h0000_4000);
        tick();
        idle();
        pop_reg(5'd14);

        // Exception and ERET together
        bus.ex_wb = 1'b1; bus.ex_code = 5'd0; bus.eret_wb = 1'b1;
        bus.wb_pc = 32'h0000_5000;
        push("both_eret",  32'h0);
        push("both_npc",   32'h0000_0080);
        push("both_flush", 32'h1);
        #1;
        pop_cmp({31'b0, bus.cp0_eret});
        pop_cmp(bus.cp0_npc);
        pop_cmp({31'b0, bus.cp0_flush});
        push("both_exl",   32'h1);
        push("both_epc",   32'h0000_5000);
        push("both_cause", 32'h0);
        tick();
        idle();
        pop_cmp({31'b0, bus.cp0_exl});
        pop_reg(5'd14);
        pop_reg(5'd13);

        // IP7 set wins over halt-entry clear
        bus.ext_int = 6'b100000;
        tick();
        bus.ex_wb = 1'b1; bus.ex_code = 5'd1; bus.wb_pc = 32'h0000_6000;
        push("setwin_ip7", 32'h80);
        push("setwin_hlt", 32'h1);
        tick();
        idle();
        bus.ext_int = 6'h00;
        pop_cmp({24'b0, bus.cp0_int_sig});
        pop_cmp({31'b0, bus.cp0_hlt});
        bus.ex_wb = 1'b1; bus.ex_code = 5'd2;
        push("setwin_resume", 32'h0);
        tick();
        idle();
        pop_cmp({31'b0, bus.cp0_hlt});

        // MTC0 Cause touches only IP[1:0]
        bus.ext_int = 6'b001010;
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd13; bus.cp0_wdata = 32'hFFFF_FFFF;
        push("mtc0_cause", 32'h0000_AB08);
        tick();
        idle();
        pop_reg(5'd13);
        bus.ext_int = 6'b000101;
        push("cause_follow", 32'h0000_9708);
        tick();
        pop_reg(5'd13);
        bus.ext_int = 6'h00;

        // Reset while halted
        bus.ex_wb = 1'b1; bus.ex_code = 5'd1; bus.wb_pc = 32'h0000_7000;
        push("pre_rst_hlt", 32'h1);
        tick();
        idle();
        pop_cmp({31'b0, bus.cp0_hlt});
        rst = 1'b1;
        push("hrst_hlt",    32'h0);
        push("hrst_status", 32'h0000_C001);
        push("hrst_cause",  32'h0);
        push("hrst_epc",    32'h0);
        tick();
        rst = 1'b0;
        pop_cmp({31'b0, bus.cp0_hlt});
        pop_reg(5'd12);
        pop_reg(5'd13);
        pop_reg(5'd14);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 register file and exception sequencer for the 5-stage MIPS pipeline; the state holder on the other end of the control unit's exception interface. It does four things:
- consumes the WB-stage exception, ERET and MTC0 requests produced by `cu`;
- latches external interrupt lines into Cause.IP;
- maintains Status/Cause/EPC and a RUN/HALT state machine;
- returns IE, EXL, interrupt mask, pending bits, halt, flush and the redirect PC that `cu` and the PC mux consume.

## Interface
Parameters:
- EXC_VEC, 32'h0000_0080, redirect target for ordinary interrupts (ex_code 0)
- HALT_VEC, 32'h0000_0100, redirect target on halt entry and while halted
- STATUS_RST, 32'h0000_C001, Status reset value (IM7=IM6=1, EXL=0, IE=1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ext_int  in  6  external interrupt lines → IP[7:2]
- ex_wb  in  1  exception accepted for the instruction in WB
- ex_code  in  5  cause code with ex_wb: 0 INT, 1 HLT, 2 RESUME
- eret_wb  in  1  ERET in WB
- branch_delay  in  1  WB instruction is in a branch delay slot
- wb_pc  in  32  PC of WB instruction
- cp0_we  in  1  MTC0 write enable (WB)
- cp0_waddr  in  5  MTC0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rdata  out  32  MFC0 data, combinational
- cp0_ie  out  1  Status.IE
- cp0_exl  out  1  Status.EXL
- cp0_int_mask  out  8  Status.IM
- cp0_int_sig  out  8  Cause.IP
- cp0_hlt  out  1  FSM in HALT
- cp0_eret  out  1  = eret_wb & !ex_wb
- cp0_flush  out  1  = ex_wb | eret_wb
- cp0_npc  out  32  redirect PC, valid when ex_wb | cp0_eret | cp0_hlt
- cp0_epc  out  32  EPC register

## Operation
Register map (read of any other number returns 0):
- 12 Status = {16'b0, IM[7:0], 6'b0, EXL, IE}
- 13 Cause = {BD, 15'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}
- 14 EPC

FSM states RUN and HALT:
- RUN → HALT on ex_wb with ex_code 1
- HALT → RUN on ex_wb with ex_code 2
- All other events leave the state unchanged
- cp0_hlt = (state == HALT)

Per-cycle update priority: rst > ex_wb > eret_wb > cp0_we.
- cp0_we is ignored in any cycle with ex_wb or eret_wb, because the WB instruction is squashed.

On ex_wb with code 0 or 1:
- EXL ← 1
- ExcCode ← ex_code
- BD ← branch_delay
- EPC ← branch_delay ? wb_pc − 4 : wb_pc

On ex_wb with code 2:
- EXL ← 0
- ExcCode ← 2
- EPC and BD are unchanged

On eret_wb:
- EXL ← 0
- No other register changes

cp0_npc, combinational, by priority:
- ex_wb code 0 → EXC_VEC
- ex_wb code 1 → HALT_VEC
- ex_wb code 2 → EPC
- eret_wb → EPC
- cp0_hlt → HALT_VEC
- otherwise EXC_VEC (don't-care)

Interrupt pending bits (Cause.IP):
- IP[7:6] are sticky. A bit sets when its ext_int[5:4] line is high. IP7 clears on ex_wb code 1; IP6 clears on ex_wb code 2.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- IP[5:2] ← ext_int[3:0] every cycle (registered level).
- IP[1:0] are written only by MTC0 to Cause (cp0_wdata[9:8]).

MTC0 write effects:
- MTC0 to Status writes IM, EXL and IE.
- MTC0 to Cause writes IP[1:0] only.
- MTC0 to EPC writes all 32 bits.
- Writes to any other number are dropped.

## Timing
- Reset values:
  - Status = STATUS_RST
  - Cause = 0, EPC = 0, state = RUN
  - Derived outputs: cp0_hlt = 0, cp0_int_sig = 0, cp0_ie = 1, cp0_exl = 0, cp0_int_mask = 8'hC0
- cp0_rdata is a combinational read of current register state, with no same-cycle write forwarding.
  - `cu` stalls MFC0 hazards, so the bench must not expect bypass.
- cp0_flush, cp0_eret and cp0_npc are combinational from the inputs and the current EPC/state. The redirect takes effect in the same cycle as the request.
- Register and FSM updates become visible the cycle after the event.
  - Example: cp0_hlt rises one cycle after ex_wb code 1.
- An ext_int pulse one cycle wide is captured in IP7/IP6. cp0_int_sig reflects it the next cycle.
- ex_wb and eret_wb in the same cycle: the exception wins, cp0_eret = 0, and EXL ← 1.
- Asserting rst during HALT returns to RUN next cycle with all reset values.

## Test plan
- Reset: assert rst for 2 cycles → Status = 32'h0000_C001, Cause = 0, EPC = 0, cp0_hlt = 0; MFC0 of register 20 returns 0.
- Halt entry: pulse ext_int[5]; next cycle cp0_int_sig = 8'h80; then ex_wb, code 1, wb_pc = 32'h0000_3010, branch_delay = 1.
  - Same cycle: cp0_npc = 32'h0000_0100, cp0_flush = 1.
  - Next cycle: cp0_hlt = 1, EXL = 1, EPC = 32'h0000_300C, BD = 1, IP7 = 0.
- Resume from HALT: pulse ext_int[4], then ex_wb with code 2.
  - Same cycle: cp0_npc = 32'h0000_300C.
  - Next cycle: cp0_hlt = 0, EXL = 0, IP6 = 0, ExcCode = 2.
- ERET vs MTC0: eret_wb = 1 with cp0_we = 1, waddr = 14, wdata = 32'hDEAD_BEEF → cp0_npc = old EPC; EPC is unchanged next cycle; EXL = 0.
- Simultaneous events:
  - ex_wb code 0 with eret_wb → cp0_eret = 0, cp0_npc = 32'h0000_0080, EXL = 1 next cycle.
  - ext_int[5] high in the same cycle as ex_wb code 1 → IP7 remains 1.
- MTC0 Cause: wdata = 32'hFFFF_FFFF → only IP[1:0] become 1; ExcCode and BD are unchanged; IP[5:2] keep following ext_int.
